// File: rtl/instr_fetch_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage (master)
// and the instruction memory (slave).
interface instr_fetch_if;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/instr_fetch.sv
// LEGv8 instruction fetch stage: PC register, req/ack fetch FSM and branch target logic.
// Optional FETCH_PERF_CNT_EN adds free-running fetch and stall counters.
module instr_fetch #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter logic [63:0] PC_STEP  = 64'd4
) (
    input  logic         clk,
    input  logic         rst,
    instr_fetch_if.master imem,
    input  logic         stall_i,
    input  logic         branch_i,
    input  logic         uncond_branch_i,
    input  logic         zero_i,
    input  logic [63:0]  sext_imm_i,
    output logic [31:0]  instr_o,
    output logic [10:0]  opcode_o,
    output logic         instr_valid_o,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]  fetch_count_o,
    output logic [31:0]  stall_count_o,
`endif
    output logic [63:0]  pc_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_EXEC = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [63:0] pc_out_q, pc_out_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;
    logic        taken;

    assign taken = uncond_branch_i | (branch_i & zero_i);

    always_comb begin
        // NOTE: every next-state signal takes its hold value first so no path infers a latch.
        state_d  = state_q;
        pc_d     = pc_q;
        pc_out_d = pc_out_q;
        instr_d  = instr_q;
        valid_d  = valid_q;
        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                if (imem.imem_ack) begin
                    instr_d  = imem.imem_rdata;
                    pc_out_d = pc_q;
                    valid_d  = 1'b1;
                    state_d  = S_EXEC;
                end
            end
            S_EXEC: begin
                // Branch operands are only meaningful on the retiring edge.
                if (!stall_i) begin
                    valid_d = 1'b0;
                    state_d = S_REQ;
                    pc_d    = taken ? pc_out_q + (sext_imm_i << 2) : pc_out_q + PC_STEP;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            pc_out_q <= RESET_PC;
            instr_q  <= 32'h0;
            valid_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking so all state registers update together from pre-edge values.
            state_q  <= state_d;
            pc_q     <= pc_d;
            pc_out_q <= pc_out_d;
            instr_q  <= instr_d;
            valid_q  <= valid_d;
        end
    end

    // Request is decoded from state so an async reset drops it immediately.
    assign imem.imem_req  = (state_q == S_REQ);
    assign imem.imem_addr = pc_q;
    assign instr_o        = instr_q;
    assign opcode_o       = instr_q[31:21];
    assign instr_valid_o  = valid_q;
    assign pc_o           = pc_out_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, stall_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt_q <= 32'h0;
            stall_cnt_q <= 32'h0;
        end else begin
            if (state_q == S_REQ && imem.imem_ack)
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if ((state_q == S_REQ && !imem.imem_ack) || (state_q == S_EXEC && stall_i))
                stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign fetch_count_o = fetch_cnt_q;
    assign stall_count_o = stall_cnt_q;
`endif

endmodule
